requant_stage: RTL

Streaming requantization stage directly downstream of the fully-connected accelerator. It consumes the int32 accumulator outputs (bias already added) one element at a time and produces int8 activations using TFLite fixed-point requantization: 32×32 multiply, rounding-doubling high part, rounding right shift, output zero point, and clamp. The clamp also implements fused ReLU/ReLU6. Control is a start/done job interface; data moves over valid/ready streams.

---
 rtl/requant_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/requant_stage.sv
// Streaming int32 -> int8 requantizer: 32x32 multiply, rounding-doubling high part,
// rounding right shift, zero-point add and clamp, wrapped in a start/done job FSM.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; config latched on the start cycle
// ST_RUN  | accepting words and draining the 3-stage pipeline
// ST_DONE | one-cycle done pulse, then back to ST_IDLE
module requant_stage #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] count_i,
    input  logic [31:0]          multiplier_i,
    input  logic [4:0]           shift_i,
    input  logic [OUT_WIDTH-1:0] out_zero_point_i,
    input  logic [OUT_WIDTH-1:0] act_min_i,
    input  logic [OUT_WIDTH-1:0] act_max_i,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [ACC_WIDTH-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [OUT_WIDTH-1:0] out_data_o,
    output logic                 out_last_o
);
    localparam int PW = ACC_WIDTH + 32;
    localparam logic signed [PW-1:0] HALF_Q31 = {{(PW-31){1'b0}}, 1'b1, 30'd0};
    localparam logic signed [PW-1:0] SAT_PROD = {{(PW-63){1'b0}}, 1'b1, 62'd0};

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                       state_q;
    logic [CNT_WIDTH-1:0]         cnt_q, acc_q;
    logic signed [31:0]           mult_q;
    logic [4:0]                   shift_q;
    logic [OUT_WIDTH-1:0]         zp_q, amin_q, amax_q;
    logic                         v1_q, v2_q, v3_q, l1_q, l2_q, last_q;
    logic signed [PW-1:0]         p1_q;
    logic signed [31:0]           h2_q;
    logic [OUT_WIDTH-1:0]         data_q;

    logic                         adv, in_fire, out_fire, l_d;
    logic signed [PW-1:0]         p_d, ps;
    logic signed [31:0]           h_d;
    logic signed [32:0]           hs, rnd, r;
    logic signed [33:0]           t, tmin, tmax, t1, t2;
    logic [OUT_WIDTH-1:0]         out_d;

    assign adv        = !v3_q || out_ready_i;
    assign in_ready_o = (state_q == ST_RUN) && adv && (acc_q < cnt_q);
    assign in_fire    = in_ready_o && in_valid_i;
    assign out_fire   = v3_q && out_ready_i;

    assign p_d = $signed({{32{in_data_i[ACC_WIDTH-1]}}, in_data_i})
               * $signed({{ACC_WIDTH{mult_q[31]}}, mult_q});
    assign l_d = (acc_q == (cnt_q - CNT_WIDTH'(1)));

    // Only -2^31 * -2^31 reaches 2^62; its doubled high part overflows int32.
    assign ps  = p1_q + HALF_Q31;
    assign h_d = (p1_q == SAT_PROD) ? 32'sh7FFF_FFFF : ps[62:31];

    always_comb begin
        hs   = {h2_q[31], h2_q};
        rnd  = (shift_q == 5'd0) ? 33'sd0 : (33'sd1 <<< (shift_q - 5'd1));
        r    = (hs + rnd) >>> shift_q;
        t    = {r[32], r} + {{(34-OUT_WIDTH){zp_q[OUT_WIDTH-1]}}, zp_q};
        tmin = {{(34-OUT_WIDTH){amin_q[OUT_WIDTH-1]}}, amin_q};
        tmax = {{(34-OUT_WIDTH){amax_q[OUT_WIDTH-1]}}, amax_q};
        t1   = (t < tmin) ? tmin : t;
        t2   = (t1 > tmax) ? tmax : t1;
        out_d = t2[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mult_q  <= '0;
            shift_q <= '0;
            zp_q    <= '0;
            amin_q  <= '0;
            amax_q  <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            l1_q    <= 1'b0;
            l2_q    <= 1'b0;
            last_q  <= 1'b0;
            p1_q    <= '0;
            h2_q    <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) begin
                    cnt_q   <= count_i;
                    acc_q   <= '0;
                    mult_q  <= multiplier_i;
                    shift_q <= shift_i;
                    zp_q    <= out_zero_point_i;
                    amin_q  <= act_min_i;
                    amax_q  <= act_max_i;
                    state_q <= (count_i == '0) ? ST_DONE : ST_RUN;
                end
                ST_RUN:  if (out_fire && last_q) state_q <= ST_DONE;
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase

            if (in_fire) acc_q <= acc_q + CNT_WIDTH'(1);

            if (adv) begin
                v1_q <= in_fire;
                if (in_fire) begin
                    p1_q <= p_d;
                    l1_q <= l_d;
                end
                v2_q <= v1_q;
                h2_q <= h_d;
                l2_q <= l1_q;
                v3_q <= v2_q;
                last_q <= v2_q && l2_q;
                if (v2_q) data_q <= out_d;
            end
        end
    end

    assign busy_o      = (state_q == ST_RUN);
    assign done_o      = (state_q == ST_DONE);
    assign out_valid_o = v3_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;
endmodule
